router_sync: RTL

- Glue stage between the router input FSM and the three per-destination FIFOs.
- Latches the destination address from the packet header and steers the FSM's single write strobe to exactly one FIFO.
- Returns that FIFO's full flag to the FSM and generates vld_out from the FIFO empty flags.
- Runs a per-channel read-timeout watchdog that pulses soft_reset to flush a FIFO when no destination read arrives in time.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_sync_if.sv | 32 +++
 rtl/router_timeout.sv | 52 +++++
 rtl/router_sync.sv | 74 +++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and types for the router sync stage
//
// Purpose : channel count, address encoding, header field positions and the
//           default read-timeout used by router_sync and its watchdogs.
// Ports   : none (package).

package router_pkg;

  localparam int NUM_CH          = 3;
  localparam int ADDR_W          = 2;
  localparam int TIMEOUT_DEFAULT = 30;

  typedef logic [ADDR_W-1:0] addr_t;

  // Address 3 has no FIFO behind it; packets sent there are dropped.
  localparam addr_t ADDR_INVALID = 2'b11;

  // Header byte layout: destination address in [1:0], payload length in [7:2].
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

endpackage

// File: rtl/router_sync_if.sv
// rtl/router_sync_if.sv - bus between router FSM/FIFOs and the sync stage
//
// Purpose : groups the FSM strobes, FIFO status flags and per-channel
//           steering outputs of router_sync.
// Modports: slave  - the sync stage (router_sync)
//           master - the surrounding FSM / FIFO / destination side

interface router_sync_if;
  import router_pkg::*;

  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;

  modport slave (
    input  detect_add, data_in, write_enb_reg, read_enb, empty, full,
    output write_enb, fifo_full, vld_out, soft_reset
  );

  modport master (
    output detect_add, data_in, write_enb_reg, read_enb, empty, full,
    input  write_enb, fifo_full, vld_out, soft_reset
  );

endinterface

// File: rtl/router_timeout.sv
// rtl/router_timeout.sv - single-channel read-timeout watchdog
//
// Purpose : counts consecutive cycles in which the channel holds valid data
//           and is not read; after TIMEOUT such edges it pulses soft_reset for
//           one cycle so the FIFO gets flushed, then starts counting again.
// Ports   : clock      - system clock, rising edge
//           resetn     - asynchronous active-low reset
//           vld        - channel has data (FIFO not empty)
//           rd         - destination read request
//           soft_reset - registered one-cycle flush pulse

module router_timeout #(
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          soft_reset_q, soft_reset_d;

  always_comb begin
    cnt_d        = cnt_q;
    soft_reset_d = 1'b0;
    if (!vld || rd) begin
      cnt_d = '0;
    end else if (cnt_q == TW'(TIMEOUT - 1)) begin
      cnt_d        = '0;
      soft_reset_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync.sv
// rtl/router_sync.sv - address latch, write steering and FIFO watchdogs
//
// Purpose : latches the packet destination from the header, steers the FSM
//           write strobe to one FIFO, returns that FIFO's full flag, derives
//           vld_out from the empty flags and runs one read-timeout watchdog
//           per channel.
// Ports   : clock  - system clock, rising edge
//           resetn - asynchronous active-low reset
//           bus    - router_sync_if.slave: detect_add, data_in, write_enb_reg,
//                    read_enb, empty, full in; write_enb, fifo_full, vld_out,
//                    soft_reset out

module router_sync #(
  parameter int NUM_CH  = router_pkg::NUM_CH,
  parameter int TIMEOUT = router_pkg::TIMEOUT_DEFAULT
) (
  input  logic           clock,
  input  logic           resetn,
  router_sync_if.slave   bus
);
  import router_pkg::*;

  addr_t             addr_q, addr_d;
  logic [NUM_CH-1:0] write_enb_w;
  logic              fifo_full_w;
  logic [NUM_CH-1:0] soft_reset_w;

  // A header arriving in the same cycle as a write does not affect that
  // write: steering below always uses the registered address.
  always_comb begin
    addr_d = addr_q;
    if (bus.detect_add) begin
      addr_d = bus.data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= ADDR_INVALID;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Address 3 matches no channel, so writes are dropped and full reads 0.
  always_comb begin
    write_enb_w = '0;
    fifo_full_w = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        write_enb_w[i] = bus.write_enb_reg;
        fifo_full_w    = bus.full[i];
      end
    end
  end

  assign bus.write_enb  = write_enb_w;
  assign bus.fifo_full  = fifo_full_w;
  assign bus.vld_out    = ~bus.empty;
  assign bus.soft_reset = soft_reset_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdog
    router_timeout #(
      .TIMEOUT (TIMEOUT)
    ) u_timeout (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (~bus.empty[g]),
      .rd         (bus.read_enb[g]),
      .soft_reset (soft_reset_w[g])
    );
  end

endmodule
